// File: rtl/ace_ack_sched_pkg.sv
// ace_ack_sched_pkg: width helpers shared by the ack scheduler and its order FIFO.
package ace_ack_sched_pkg;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned cnt_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/ace_ack_sched_fifo.sv
// ace_ack_sched_fifo: non-fall-through order FIFO holding slave port indices.
module ace_ack_sched_fifo
  import ace_ack_sched_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned AW = idx_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd, r_wr;
  logic [CW-1:0]         r_cnt;
  logic                  w_push, w_pop;
  assign full_o  = r_cnt == CW'(DEPTH);
  assign empty_o = r_cnt == '0;
  assign w_push  = push_i && (!full_o || pop_i);
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end
endmodule

// File: rtl/ace_ack_sched.sv
// ace_ack_sched: reorders per-slave-port RACK/WACK pulses into response completion
// order and forwards them one per cycle to the master port.
module ace_ack_sched
  import ace_ack_sched_pkg::*;
#(
  parameter int unsigned NoSlvPorts = 32'd1,
  parameter int unsigned MaxTrans   = 32'd8,
  parameter bit          RegAck     = 1'b0,
  localparam int unsigned IdxWidth  = idx_width(NoSlvPorts),
  localparam int unsigned CntWidth  = cnt_width(MaxTrans)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  done_valid_i,
  input  logic [IdxWidth-1:0]   done_idx_i,
  output logic                  done_ready_o,
  input  logic [NoSlvPorts-1:0] slv_ack_i,
  output logic                  mst_ack_o,
  output logic                  err_o
);
  logic [CntWidth-1:0]   r_pend [NoSlvPorts];
  logic [CntWidth-1:0]   r_cred [NoSlvPorts];
  logic [NoSlvPorts-1:0] w_pend_nz, w_cred_nz, w_ack_ok;
  logic [IdxWidth-1:0]   w_head;
  logic                  w_full, w_empty, w_push, w_fwd, r_fwd, r_err;
  assign done_ready_o = !w_full;
  assign w_push       = done_valid_i && done_ready_o;
  assign w_ack_ok     = slv_ack_i & w_pend_nz;
  assign w_fwd        = !w_empty && (w_cred_nz[w_head] || w_ack_ok[w_head]);
  assign mst_ack_o    = RegAck ? r_fwd : w_fwd;
  assign err_o        = r_err;
  ace_ack_sched_fifo #(
    .DEPTH      (MaxTrans),
    .DATA_WIDTH (IdxWidth)
  ) u_order (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (done_idx_i),
    .pop_i   (w_fwd),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );
  // Net update per port: accepted ack moves pend->cred, forward drains cred, push adds pend.
  for (genvar i = 0; i < NoSlvPorts; i++) begin : g_port
    logic w_pop_i, w_push_i;
    assign w_pend_nz[i] = r_pend[i] != '0;
    assign w_cred_nz[i] = r_cred[i] != '0;
    assign w_pop_i      = w_fwd && (w_head == IdxWidth'(i));
    assign w_push_i     = w_push && (done_idx_i == IdxWidth'(i));
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pend[i] <= '0;
        r_cred[i] <= '0;
      end else begin
        r_pend[i] <= r_pend[i] - CntWidth'(w_ack_ok[i]) + CntWidth'(w_push_i);
        r_cred[i] <= r_cred[i] + CntWidth'(w_ack_ok[i]) - CntWidth'(w_pop_i);
      end
    end
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (32'(r_pend[i]) + 32'(r_cred[i]) <= MaxTrans));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fwd <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_fwd <= w_fwd;
      r_err <= r_err || |(slv_ack_i & ~w_pend_nz);
    end
  end
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && w_full && !w_fwd));
  a_idx_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(done_valid_i && 32'(done_idx_i) >= NoSlvPorts));
  a_fwd_nonempty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_fwd && w_empty));
endmodule

// File: tb/tb_ace_ack_sched.sv
// tb_ace_ack_sched: directed scoreboard bench; expected forward cycles are queued by
// the stimulus and matched by per-DUT monitors against observed mst_ack_o pulses.
module tb_ace_ack_sched;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       a_dv = 0, a_idx = 0, a_rdy, a_mack, a_err;
  logic       b_dv = 0, b_idx = 0, b_rdy, b_mack, b_err;
  logic [1:0] a_ack = 0, b_ack = 0;
  int cyc = 0, checks = 0, errors = 0;
  int qa[$], qb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ace_ack_sched #(.NoSlvPorts(2), .MaxTrans(4), .RegAck(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .done_valid_i(a_dv), .done_idx_i(a_idx),
    .done_ready_o(a_rdy), .slv_ack_i(a_ack), .mst_ack_o(a_mack), .err_o(a_err));
  ace_ack_sched #(.NoSlvPorts(2), .MaxTrans(4), .RegAck(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .done_valid_i(b_dv), .done_idx_i(b_idx),
    .done_ready_o(b_rdy), .slv_ack_i(b_ack), .mst_ack_o(b_mack), .err_o(b_err));
  always @(negedge clk) begin
    int e;
    if (rst_n && a_mack) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_mack: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = qa.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL a_mack: pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end
  always @(negedge clk) begin
    int e;
    if (rst_n && b_mack) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_mack: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = qb.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL b_mack: pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  initial begin
    step(3);
    check("reset a_rdy", a_rdy, 1);
    check("reset a_err", a_err, 0);
    check("reset a_mack", a_mack, 0);
    check("reset b_mack", b_mack, 0);
    check("reset b_err", b_err, 0);
    rst_n = 1;
    step();
    // in-order single port
    a_dv = 1; a_idx = 0; step();
    a_dv = 0; step();
    a_ack = 2'b01; qa.push_back(cyc); step();
    a_ack = 0; step();
    check("a_rdy after drain", a_rdy, 1);
    // cross-port reorder: port 0 acks early, becomes credit behind port 1
    a_dv = 1; a_idx = 1; step();
    a_idx = 0; step();
    a_dv = 0; step();
    a_ack = 2'b01; step();
    a_ack = 0; step(2);
    a_ack = 2'b10; qa.push_back(cyc); qa.push_back(cyc + 1); step();
    a_ack = 0; step(2);
    // full FIFO with a stalled fifth completion
    a_dv = 1; a_idx = 0; step(4);
    a_dv = 0; step();
    check("a_rdy full", a_rdy, 0);
    a_dv = 1; a_idx = 1; step();
    check("a_rdy full stalled", a_rdy, 0);
    a_ack = 2'b01; qa.push_back(cyc); step();
    a_ack = 0;
    check("a_rdy after pop", a_rdy, 1);
    step();
    a_dv = 0;
    check("a_rdy refilled", a_rdy, 0);
    a_ack = 2'b01; qa.push_back(cyc); step();
    qa.push_back(cyc); step();
    qa.push_back(cyc); step();
    a_ack = 2'b10; qa.push_back(cyc); step();
    a_ack = 0; step();
    check("a_err clean", a_err, 0);
    // spurious ack with nothing pending
    a_ack = 2'b10; step();
    a_ack = 0;
    check("a_err spurious", a_err, 1);
    step(3);
    check("a_err sticky", a_err, 1);
    // RegAck=1 back-to-back
    b_dv = 1; b_idx = 0; step(3);
    b_dv = 0; step();
    b_ack = 2'b01;
    qb.push_back(cyc + 1); qb.push_back(cyc + 2); qb.push_back(cyc + 3);
    step(3);
    b_ack = 0; step(2);
    // ack in the same cycle as its own completion
    b_dv = 1; b_idx = 1; b_ack = 2'b10; step();
    b_dv = 0; b_ack = 0;
    check("b_err same-cycle", b_err, 1);
    check("b_rdy pending", b_rdy, 1);
    step();
    b_ack = 2'b10; qb.push_back(cyc + 1); step();
    b_ack = 0; step(3);
    // reset mid-flight with credits held behind an unacked head
    a_dv = 1; a_idx = 0; step();
    a_idx = 1; step(2);
    a_idx = 0; step();
    a_dv = 0;
    a_ack = 2'b10; step(2);
    a_ack = 0;
    check("a_rdy before reset", a_rdy, 0);
    #2 rst_n = 0;
    #1;
    check("a_rdy in reset", a_rdy, 1);
    check("a_err in reset", a_err, 0);
    check("a_mack in reset", a_mack, 0);
    step(2);
    rst_n = 1;
    step(6);
    check("a_rdy after reset", a_rdy, 1);
    check("qa drained", qa.size(), 0);
    check("qb drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
